// File: rtl/chimera_cluster_boot_seq.sv
// rtl/chimera_cluster_boot_seq.sv - per-cluster clock/reset/boot sequencer.
// Optional IRQ wake-up stage is built when CHIMERA_CLU_BOOT_IRQ_EN is defined.
module chimera_cluster_boot_seq #(
  parameter int unsigned NrCores       = 9,
  parameter int unsigned ClkEnCycles   = 4,
  parameter int unsigned RstHoldCycles = 8,
  parameter int unsigned IrqCycles     = 2
) (
  input  logic               soc_clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [31:0]        boot_addr_i,
  input  logic               widemem_bypass_i,
  output logic               clu_clk_en_o,
  output logic               clu_rst_no,
  output logic [31:0]        boot_addr_o,
  output logic               widemem_bypass_o,
  output logic [NrCores-1:0] msip_o,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2:0]         state_o
);

  localparam int unsigned MaxA      = (ClkEnCycles > RstHoldCycles) ? ClkEnCycles : RstHoldCycles;
  localparam int unsigned MaxCycles = (MaxA > IrqCycles) ? MaxA : IrqCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] ClkEnLast   = CntW'(ClkEnCycles - 1);
  localparam logic [CntW-1:0] RstHoldLast = CntW'(RstHoldCycles - 1);
`ifdef CHIMERA_CLU_BOOT_IRQ_EN
  localparam logic [CntW-1:0] IrqLast     = CntW'(IrqCycles - 1);
`endif

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_CLK_ON  = 3'd1,
    ST_RST_REL = 3'd2,
    ST_IRQ     = 3'd3,
    ST_RUN     = 3'd4,
    ST_RST_ON  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              capture;
  logic              clk_en_d, rst_n_d, busy_d, ready_d;
  logic [NrCores-1:0] msip_d;

  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_OFF;
      cnt_q            <= '0;
      clu_clk_en_o     <= 1'b0;
      clu_rst_no       <= 1'b0;
      msip_o           <= '0;
      busy_o           <= 1'b0;
      ready_o          <= 1'b0;
      boot_addr_o      <= 32'h0;
      widemem_bypass_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clu_clk_en_o <= clk_en_d;
      clu_rst_no   <= rst_n_d;
      msip_o       <= msip_d;
      busy_o       <= busy_d;
      ready_o      <= ready_d;
      if (capture) begin
        boot_addr_o      <= boot_addr_i;
        widemem_bypass_o <= widemem_bypass_i;
      end
    end
  end

  assign state_o = state_q;

  // Stop aborts any boot stage before its dwell expiry is considered.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (start_i && !stop_i) begin
          state_d = ST_CLK_ON;
          capture = 1'b1;
        end
      end
      ST_CLK_ON: begin
        if (stop_i)                  state_d = ST_RST_ON;
        else if (cnt_q == ClkEnLast) state_d = ST_RST_REL;
      end
      ST_RST_REL: begin
        if (stop_i) state_d = ST_RST_ON;
        else if (cnt_q == RstHoldLast) begin
`ifdef CHIMERA_CLU_BOOT_IRQ_EN
          state_d = ST_IRQ;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef CHIMERA_CLU_BOOT_IRQ_EN
      ST_IRQ: begin
        if (stop_i)                state_d = ST_RST_ON;
        else if (cnt_q == IrqLast) state_d = ST_RUN;
      end
`endif
      ST_RUN: begin
        if (stop_i) state_d = ST_RST_ON;
      end
      ST_RST_ON: begin
        if (cnt_q == RstHoldLast) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Counter only runs in timed states, so it never wraps while idle.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && state_q != ST_OFF && state_q != ST_RUN) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    clk_en_d = 1'b0;
    rst_n_d  = 1'b0;
    msip_d   = '0;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
    unique case (state_d)
      ST_OFF: ;
      ST_CLK_ON: begin
        clk_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      ST_RST_REL: begin
        clk_en_d = 1'b1;
        rst_n_d  = 1'b1;
        busy_d   = 1'b1;
      end
`ifdef CHIMERA_CLU_BOOT_IRQ_EN
      ST_IRQ: begin
        clk_en_d = 1'b1;
        rst_n_d  = 1'b1;
        msip_d   = {NrCores{1'b1}};
        busy_d   = 1'b1;
      end
`endif
      ST_RUN: begin
        clk_en_d = 1'b1;
        rst_n_d  = 1'b1;
        ready_d  = 1'b1;
      end
      ST_RST_ON: begin
        clk_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chimera_cluster_boot_seq.sv
// tb/tb_chimera_cluster_boot_seq.sv - directed scoreboard bench for chimera_cluster_boot_seq.
module tb_chimera_cluster_boot_seq;

`ifdef CHIMERA_CLU_BOOT_IRQ_EN
  localparam int IrqLen = 2;
`else
  localparam int IrqLen = 0;
`endif
  localparam int RunCycle = 13 + IrqLen;

  logic        clk = 1'b0;
  logic        rst_ni, start_i, stop_i, widemem_bypass_i;
  logic [31:0] boot_addr_i;
  logic        clu_clk_en_o, clu_rst_no, widemem_bypass_o, busy_o, ready_o;
  logic [31:0] boot_addr_o;
  logic [8:0]  msip_o;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic        clk_en;
    logic        rst_n;
    logic [8:0]  msip;
    logic        busy;
    logic        ready;
    logic [31:0] ba;
    logic        wb;
  } exp_t;

  exp_t sb[$];

  chimera_cluster_boot_seq dut (
    .soc_clk_i        (clk),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .boot_addr_i      (boot_addr_i),
    .widemem_bypass_i (widemem_bypass_i),
    .clu_clk_en_o     (clu_clk_en_o),
    .clu_rst_no       (clu_rst_no),
    .boot_addr_o      (boot_addr_o),
    .widemem_bypass_o (widemem_bypass_o),
    .msip_o           (msip_o),
    .busy_o           (busy_o),
    .ready_o          (ready_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  // Output table per state, independent of transition logic.
  function automatic exp_t exp_of(input int st, input logic [31:0] ba, input logic wb);
    exp_t e;
    e = '0;
    e.st = 3'(st);
    e.ba = ba;
    e.wb = wb;
    case (st)
      1: begin e.clk_en = 1; e.busy = 1; end
      2: begin e.clk_en = 1; e.rst_n = 1; e.busy = 1; end
      3: begin e.clk_en = 1; e.rst_n = 1; e.busy = 1; e.msip = 9'h1FF; end
      4: begin e.clk_en = 1; e.rst_n = 1; e.ready = 1; end
      5: begin e.clk_en = 1; e.busy = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Expected boot state at cycle c (cycle 1 follows the edge that accepted start).
  function automatic int boot_state(input int c);
    if (c <= 4)        return 1;
    if (c <= 12)       return 2;
    if (c < RunCycle)  return 3;
    return 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_state"},  64'(state_o),          64'(e.st));
    chk({tag, "_clk_en"}, 64'(clu_clk_en_o),     64'(e.clk_en));
    chk({tag, "_rst_n"},  64'(clu_rst_no),       64'(e.rst_n));
    chk({tag, "_msip"},   64'(msip_o),           64'(e.msip));
    chk({tag, "_busy"},   64'(busy_o),           64'(e.busy));
    chk({tag, "_ready"},  64'(ready_o),          64'(e.ready));
    chk({tag, "_baddr"},  64'(boot_addr_o),      64'(e.ba));
    chk({tag, "_bypass"}, 64'(widemem_bypass_o), 64'(e.wb));
  endtask

  task automatic step(input string tag, input logic st, input logic sp,
                      input logic [31:0] ba, input logic wb, input exp_t e);
    @(negedge clk);
    start_i          = st;
    stop_i           = sp;
    boot_addr_i      = ba;
    widemem_bypass_i = wb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  // Accept a start then follow the sequence through cycle upto.
  task automatic boot(input string tag, input logic [31:0] ba, input logic wb, input int upto);
    step(tag, 1'b1, 1'b0, ba, wb, exp_of(1, ba, wb));
    for (int c = 2; c <= upto; c++)
      step(tag, 1'b0, 1'b0, 32'hFFFF_FFFF, ~wb, exp_of(boot_state(c), ba, wb));
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    boot_addr_i = 32'h0; widemem_bypass_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(exp_of(0, 32'h0, 1'b0));
    compare_outputs("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    step("idle", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(0, 32'h0, 1'b0));

    boot("boot1", 32'h3000_0000, 1'b1, RunCycle + 1);

    // A second start while running is neither taken nor queued.
    step("start_in_run", 1'b1, 1'b0, 32'h5555_0000, 1'b0, exp_of(4, 32'h3000_0000, 1'b1));
    step("run_hold", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(4, 32'h3000_0000, 1'b1));

    step("stop_run", 1'b0, 1'b1, 32'h0, 1'b0, exp_of(5, 32'h3000_0000, 1'b1));
    for (int i = 2; i <= 8; i++)
      step("rst_on", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(5, 32'h3000_0000, 1'b1));
    step("off_after_stop", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(0, 32'h3000_0000, 1'b1));

    step("start_stop_off", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, exp_of(0, 32'h3000_0000, 1'b1));
    step("stop_off", 1'b0, 1'b1, 32'h0, 1'b0, exp_of(0, 32'h3000_0000, 1'b1));

    boot("boot_abort", 32'h1000_0040, 1'b0, 7);
    step("abort_rst_rel", 1'b0, 1'b1, 32'h0, 1'b1, exp_of(5, 32'h1000_0040, 1'b0));
    step("stop_in_rst_on", 1'b0, 1'b1, 32'h0, 1'b1, exp_of(5, 32'h1000_0040, 1'b0));
    for (int c = 10; c <= 15; c++)
      step("abort_rst_on", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(5, 32'h1000_0040, 1'b0));
    step("abort_off", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(0, 32'h1000_0040, 1'b0));

    boot("boot_abort_clk", 32'h2000_0000, 1'b1, 2);
    step("abort_clk_on", 1'b0, 1'b1, 32'h0, 1'b0, exp_of(5, 32'h2000_0000, 1'b1));
    for (int c = 2; c <= 8; c++)
      step("abort_clk_rst_on", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(5, 32'h2000_0000, 1'b1));
    step("abort_clk_off", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(0, 32'h2000_0000, 1'b1));

    // Asynchronous reset in the middle of the wake-up stage.
    boot("boot_rst", 32'h7000_1000, 1'b1, 13);
    #2;
    rst_ni = 1'b0;
    #1;
    sb.push_back(exp_of(0, 32'h0, 1'b0));
    compare_outputs("async_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    step("post_rst_idle", 1'b0, 1'b0, 32'h0, 1'b0, exp_of(0, 32'h0, 1'b0));
    boot("reboot", 32'h3000_0000, 1'b0, RunCycle + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
